mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter OUTSTANDING, default 4, giving the maximum accepted-but-unanswered transactions (power of two, 2..8).
REQ-002 The block SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port resetn  in  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port inst_req  in  1  fetch request; always a read.
REQ-005 The block SHALL have port inst_addr  in  32  fetch physical address.
REQ-006 The block SHALL have port inst_size  in  3  fetch size (0=byte, 1=half, 2=word).
REQ-007 The block SHALL have port inst_addr_ok  out  1  fetch request accepted this cycle.
REQ-008 The block SHALL have port inst_data_ok  out  1  fetch read data valid on mem_rdata this cycle.
REQ-009 The block SHALL have port data_req  in  1  load/store request from execute stage.
REQ-010 The block SHALL have port data_wr  in  1  1=store, 0=load.
REQ-011 The block SHALL have port data_wstrb  in  4  store byte enables.
REQ-012 The block SHALL have port data_size  in  3  access size, same encoding as inst_size.
REQ-013 The block SHALL have port data_addr  in  32  load/store physical address (already translated).
REQ-014 The block SHALL have port data_wdata  in  32  store data.
REQ-015 The block SHALL have port data_addr_ok  out  1  data request accepted this cycle.
REQ-016 The block SHALL have port data_data_ok  out  1  load data valid on mem_rdata, or store done, this cycle.
REQ-017 The block SHALL have port mem_req  out  1  downstream request.
REQ-018 The block SHALL have port mem_wr  out  1  downstream write flag.
REQ-019 The block SHALL have port mem_wstrb  out  4  downstream byte enables.
REQ-020 The block SHALL have port mem_size  out  3  downstream size.
REQ-021 The block SHALL have port mem_addr  out  32  downstream address.
REQ-022 The block SHALL have port mem_wdata  out  32  downstream write data.
REQ-023 The block SHALL have port mem_addr_ok  in  1  downstream accepted mem_req this cycle.
REQ-024 The block SHALL have port mem_data_ok  in  1  downstream response this cycle; responses return in acceptance order.
REQ-025 The block SHALL have port mem_rdata  in  32  downstream read data; requesters sample it directly, and the block does not register it.

Function
REQ-026 The block SHALL grant combinationally: data wins if data_req=1, otherwise inst wins if inst_req=1; mem_req=(data_req|inst_req)&!full.
REQ-027 The block SHALL drive mem_wr/wstrb/size/addr/wdata from the winner; when inst wins, mem_wr=0 and mem_wstrb=0.
REQ-028 The block SHALL assert exactly one of inst_addr_ok/data_addr_ok: the winner's, equal to mem_addr_ok&mem_req; the loser's SHALL be 0.
REQ-029 The block SHALL push the owner ID (0=inst, 1=data) into an in-order owner FIFO on each mem_req&mem_addr_ok handshake; the push SHALL be visible to a data_ok arriving in the following cycle or later.
REQ-030 The block SHALL pop the FIFO head on mem_data_ok and route the response: inst_data_ok=mem_data_ok&(head==0), data_data_ok=mem_data_ok&(head==1).
REQ-031 The block SHALL accept a simultaneous push and pop in one cycle, leaving the count unchanged.
REQ-032 The block SHALL define full as count==OUTSTANDING, which blocks mem_req; a pop in the same cycle SHALL NOT unblock it (no full-bypass).
REQ-033 The block SHALL ignore mem_data_ok when count==0 (protocol error): no data_ok outputs, no pointer change.
REQ-034 The block SHALL keep pointers log2(OUTSTANDING) bits wide and wrap naturally; count is log2(OUTSTANDING)+1 bits.
REQ-035 The block SHALL add no latency: request-path outputs are combinational in the current inputs and full; response routing is combinational in mem_data_ok and head.
REQ-036 The block SHALL never interleave a requester's responses out of order; an inst fetch issued before a store completes first.

Reset
REQ-037 Asserting resetn=0 at any time SHALL asynchronously clear the pointers and count (FIFO empty); outputs SHALL then be mem_req=0 unless a request is present, and inst_data_ok=data_data_ok=0.
REQ-038 Transactions in flight at reset SHALL be dropped; the downstream is reset by the same resetn.

Structure
REQ-039 The owner-ID encoding and the size encodings SHALL live in the shared header alongside the existing EXC_/I_ constants.
REQ-040 The owner FIFO SHALL be a sub-module, owner_fifo (width 1, depth OUTSTANDING, push/pop/full/empty/head).

Verification
REQ-041 Issue inst_req and data_req together with mem_addr_ok=1 -> data_addr_ok=1, inst_addr_ok=0, mem_addr=data_addr; next cycle with inst_req only -> inst_addr_ok=1.
REQ-042 Accept inst, data, inst in order, then pulse mem_data_ok three times -> inst_data_ok, data_data_ok, inst_data_ok in that order.
REQ-043 Accept 4 requests with no response -> mem_req=0 on the 5th; mem_data_ok and a new request in the same cycle -> still blocked, accepted next cycle.
REQ-044 With count=2, same-cycle accept and response for 20 cycles -> count stays 2 and pointer wrap is correct.
REQ-045 Reset asserted mid-flight with 3 outstanding -> count=0 immediately; a stray mem_data_ok afterwards -> no data_ok output.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory arbiter: exception codes, instruction
// constants, access-size encodings, owner IDs, and the downstream command
// bundle used by the request mux.
package mem_arbiter_pkg;

  // Exception codes shared with the pipeline
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  // Instruction-side constants
  localparam logic [31:0] I_NOP          = 32'h0000_0000;
  localparam logic [31:0] I_RESET_VECTOR = 32'hBFC0_0000;

  // Access size encoding, shared by fetch, load/store and downstream
  typedef enum logic [2:0] {
    SIZE_BYTE = 3'd0,
    SIZE_HALF = 3'd1,
    SIZE_WORD = 3'd2
  } size_e;

  // Owner of an accepted downstream transaction
  localparam int OWNER_W = 1;
  typedef enum logic [OWNER_W-1:0] {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  // One downstream command as selected by the grant mux
  typedef struct packed {
    logic        wr;
    logic [3:0]  wstrb;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  // Number of bytes moved by a given size code (unknown codes count as a word)
  function automatic logic [2:0] size_to_bytes(input logic [2:0] size);
    case (size)
      SIZE_BYTE: size_to_bytes = 3'd1;
      SIZE_HALF: size_to_bytes = 3'd2;
      default:   size_to_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_owner_fifo.sv
// In-order owner FIFO: remembers who issued each accepted downstream request
// so that responses, which return in acceptance order, can be routed back.
// Push while full and pop while empty are ignored.
module owner_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int              PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0]  COUNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] slot_q [DEPTH];
  logic [DEPTH-1:0] slot_we;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;

  logic do_push;
  logic do_pop;

  assign full    = (count_q == COUNT_FULL);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = slot_q[rd_ptr_q];

  // One write enable per slot, decoded from the write pointer
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot_we
      assign slot_we[gi] = do_push && (wr_ptr_q == PTR_W'(gi));
    end
  endgenerate

  // Next pointers and occupancy; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers, cleared asynchronously to an empty FIFO
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Owner storage; cleared on reset so head is never unknown
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_we[i]) slot_q[i] <= push_data;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: merges the fetch port and the load/store port
// onto one pipelined downstream port. Data has fixed priority over fetch.
// Grant and response routing are purely combinational; the only state is the
// owner FIFO that tracks who is waiting for each in-flight response.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        resetn,
  // fetch port (read only)
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [2:0]  inst_size,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  // load/store port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [2:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  // downstream port
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [2:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  owner_e               winner;
  mem_cmd_t             inst_cmd;
  mem_cmd_t             data_cmd;
  mem_cmd_t             mem_cmd;
  logic                 handshake;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [OWNER_W-1:0]   fifo_head;
  logic [OWNER_W-1:0]   push_id;
  logic                 resp_valid;

  // Read data goes straight from downstream to the requesters
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;

  // Fixed-priority grant: a load/store beats a fetch in the same cycle
  always_comb begin
    winner = data_req ? OWNER_DATA : OWNER_INST;
  end

  // Build the two candidate commands; a fetch never writes
  always_comb begin
    inst_cmd       = '0;
    inst_cmd.wr    = 1'b0;
    inst_cmd.wstrb = 4'b0000;
    inst_cmd.size  = inst_size;
    inst_cmd.addr  = inst_addr;
    inst_cmd.wdata = '0;

    data_cmd       = '0;
    data_cmd.wr    = data_wr;
    data_cmd.wstrb = data_wstrb;
    data_cmd.size  = data_size;
    data_cmd.addr  = data_addr;
    data_cmd.wdata = data_wdata;
  end

  // Downstream request mux; a full FIFO holds off any new request, and a
  // response in the same cycle does not bypass that
  always_comb begin
    mem_cmd   = (winner == OWNER_DATA) ? data_cmd : inst_cmd;
    mem_req   = (data_req | inst_req) & ~fifo_full;
    mem_wr    = mem_cmd.wr;
    mem_wstrb = mem_cmd.wstrb;
    mem_size  = mem_cmd.size;
    mem_addr  = mem_cmd.addr;
    mem_wdata = mem_cmd.wdata;
  end

  // Acceptance goes only to the winner of this cycle's grant
  always_comb begin
    handshake    = mem_req & mem_addr_ok;
    data_addr_ok = handshake & (winner == OWNER_DATA);
    inst_addr_ok = handshake & (winner == OWNER_INST);
    push_id      = winner;
  end

  // Route each response to the owner at the FIFO head; a response with
  // nothing outstanding is a protocol error and is dropped
  always_comb begin
    resp_valid   = mem_data_ok & ~fifo_empty;
    inst_data_ok = resp_valid & (fifo_head == OWNER_INST);
    data_data_ok = resp_valid & (fifo_head == OWNER_DATA);
  end

  owner_fifo #(
    .WIDTH (OWNER_W),
    .DEPTH (OUTSTANDING)
  ) u_owner_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (handshake),
    .push_data (push_id),
    .pop       (mem_data_ok),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: priority, response ordering, full blocking,
// steady-state push/pop with pointer wrap, and reset while busy.
module tb_mem_arbiter;

  localparam int OUTS = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [2:0]  inst_size;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [2:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [2:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  // expected owner of each outstanding response, oldest first (1 = data)
  logic exp_q[$];

  mem_arbiter #(.OUTSTANDING(OUTS)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_size    (inst_size),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_wstrb    (mem_wstrb),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic idle();
    inst_req    = 1'b0;
    inst_addr   = 32'h0;
    inst_size   = 3'd2;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_wstrb  = 4'h0;
    data_size   = 3'd2;
    data_addr   = 32'h0;
    data_wdata  = 32'h0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present one request from the given owner (1 = data store, 0 = fetch)
  task automatic drive_owner(input logic own, input int idx);
    if (own) begin
      data_req   = 1'b1;
      data_wr    = 1'b1;
      data_wstrb = 4'hF;
      data_size  = 3'd2;
      data_addr  = 32'h1000_0000 + 32'(idx * 4);
      data_wdata = 32'hA500_0000 + 32'(idx);
    end else begin
      inst_req  = 1'b1;
      inst_size = 3'd2;
      inst_addr = 32'hBFC0_0000 + 32'(idx * 4);
    end
  endtask

  task automatic test_reset();
    idle();
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req, inst_data_ok, data_data_ok} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_idle: got req/iok/dok=%b want 000", {mem_req, inst_data_ok, data_data_ok});
    end
    mem_data_ok = 1'b1;
    #1;
    n_cmp++;
    if ({inst_data_ok, data_data_ok} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_stray_ok: got iok/dok=%b want 00", {inst_data_ok, data_data_ok});
    end
    mem_data_ok = 1'b0;
    inst_req    = 1'b1;
    #1;
    n_cmp++;
    if ({mem_req, inst_addr_ok, data_addr_ok} !== 3'b100) begin
      n_bad++;
      $display("FAIL reset_req_present: got req/iaok/daok=%b want 100", {mem_req, inst_addr_ok, data_addr_ok});
    end
    idle();
    @(negedge clk);
    resetn = 1'b1;
    step();
    $display("txn reset released");
  endtask

  task automatic test_priority();
    idle();
    inst_req    = 1'b1;
    inst_addr   = 32'hBFC0_0100;
    inst_size   = 3'd2;
    data_req    = 1'b1;
    data_wr     = 1'b1;
    data_wstrb  = 4'b0011;
    data_size   = 3'd1;
    data_addr   = 32'h1000_0042;
    data_wdata  = 32'hDEAD_BEEF;
    mem_addr_ok = 1'b1;
    #1;
    n_cmp++;
    if ({inst_addr_ok, data_addr_ok, mem_req} !== 3'b011) begin
      n_bad++;
      $display("FAIL prio_both_aok: got iaok/daok/req=%b want 011", {inst_addr_ok, data_addr_ok, mem_req});
    end
    n_cmp++;
    if ({mem_wr, mem_wstrb, mem_size, mem_addr, mem_wdata} !== {1'b1, 4'b0011, 3'd1, 32'h1000_0042, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL prio_data_cmd: got wr=%b strb=%h sz=%0d addr=%h wd=%h want 1 3 1 10000042 deadbeef",
               mem_wr, mem_wstrb, mem_size, mem_addr, mem_wdata);
    end
    $display("txn accept data addr=%h", mem_addr);
    step();
    data_req = 1'b0;
    #1;
    n_cmp++;
    if ({inst_addr_ok, data_addr_ok, mem_req} !== 3'b101) begin
      n_bad++;
      $display("FAIL prio_inst_aok: got iaok/daok/req=%b want 101", {inst_addr_ok, data_addr_ok, mem_req});
    end
    n_cmp++;
    if ({mem_wr, mem_wstrb, mem_size, mem_addr} !== {1'b0, 4'b0000, 3'd2, 32'hBFC0_0100}) begin
      n_bad++;
      $display("FAIL prio_inst_cmd: got wr=%b strb=%h sz=%0d addr=%h want 0 0 2 bfc00100",
               mem_wr, mem_wstrb, mem_size, mem_addr);
    end
    $display("txn accept inst addr=%h", mem_addr);
    step();
    idle();
    data_req = 1'b1;
    #1;
    n_cmp++;
    if ({inst_addr_ok, data_addr_ok, mem_req} !== 3'b001) begin
      n_bad++;
      $display("FAIL prio_no_addr_ok: got iaok/daok/req=%b want 001", {inst_addr_ok, data_addr_ok, mem_req});
    end
    step();
    idle();
    mem_data_ok = 1'b1;
    #1;
    n_cmp++;
    if ({inst_data_ok, data_data_ok} !== 2'b01) begin
      n_bad++;
      $display("FAIL prio_resp0: got iok/dok=%b want 01", {inst_data_ok, data_data_ok});
    end
    $display("txn response data");
    step();
    n_cmp++;
    if ({inst_data_ok, data_data_ok} !== 2'b10) begin
      n_bad++;
      $display("FAIL prio_resp1: got iok/dok=%b want 10", {inst_data_ok, data_data_ok});
    end
    $display("txn response inst");
    step();
    n_cmp++;
    if ({inst_data_ok, data_data_ok} !== 2'b00) begin
      n_bad++;
      $display("FAIL prio_empty_resp: got iok/dok=%b want 00", {inst_data_ok, data_data_ok});
    end
    idle();
    step();
  endtask

  task automatic test_order();
    logic own_tab [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      idle();
      drive_owner(own_tab[i], i);
      mem_addr_ok = 1'b1;
      #1;
      n_cmp++;
      if ({inst_addr_ok, data_addr_ok} !== (own_tab[i] ? 2'b01 : 2'b10)) begin
        n_bad++;
        $display("FAIL order_accept%0d: got iaok/daok=%b want %b", i, {inst_addr_ok, data_addr_ok},
                 own_tab[i] ? 2'b01 : 2'b10);
      end
      $display("txn accept owner=%0d", own_tab[i]);
      step();
    end
    idle();
    mem_data_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({inst_data_ok, data_data_ok} !== (own_tab[i] ? 2'b01 : 2'b10)) begin
        n_bad++;
        $display("FAIL order_resp%0d: got iok/dok=%b want %b", i, {inst_data_ok, data_data_ok},
                 own_tab[i] ? 2'b01 : 2'b10);
      end
      $display("txn response owner=%0d", own_tab[i]);
      step();
    end
    idle();
    step();
  endtask

  task automatic test_full();
    logic own_tab [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic drain_tab [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      idle();
      drive_owner(own_tab[i], i);
      mem_addr_ok = 1'b1;
      #1;
      n_cmp++;
      if (mem_req !== 1'b1) begin
        n_bad++;
        $display("FAIL full_fill%0d: got mem_req=%b want 1", i, mem_req);
      end
      $display("txn accept owner=%0d", own_tab[i]);
      step();
    end
    idle();
    inst_req    = 1'b1;
    mem_addr_ok = 1'b1;
    #1;
    n_cmp++;
    if ({mem_req, inst_addr_ok, data_addr_ok} !== 3'b000) begin
      n_bad++;
      $display("FAIL full_blocked: got req/iaok/daok=%b want 000", {mem_req, inst_addr_ok, data_addr_ok});
    end
    step();
    drive_owner(1'b1, 9);
    mem_data_ok = 1'b1;
    #1;
    n_cmp++;
    if ({mem_req, inst_addr_ok, data_addr_ok} !== 3'b000) begin
      n_bad++;
      $display("FAIL full_no_bypass: got req/iaok/daok=%b want 000", {mem_req, inst_addr_ok, data_addr_ok});
    end
    n_cmp++;
    if ({inst_data_ok, data_data_ok} !== 2'b10) begin
      n_bad++;
      $display("FAIL full_pop_head: got iok/dok=%b want 10", {inst_data_ok, data_data_ok});
    end
    $display("txn response owner=0 while full");
    step();
    mem_data_ok = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req, inst_addr_ok, data_addr_ok} !== 3'b101) begin
      n_bad++;
      $display("FAIL full_unblocked: got req/iaok/daok=%b want 101", {mem_req, inst_addr_ok, data_addr_ok});
    end
    $display("txn accept owner=1 after unblock");
    step();
    idle();
    mem_data_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if ({inst_data_ok, data_data_ok} !== (drain_tab[i] ? 2'b01 : 2'b10)) begin
        n_bad++;
        $display("FAIL full_drain%0d: got iok/dok=%b want %b", i, {inst_data_ok, data_data_ok},
                 drain_tab[i] ? 2'b01 : 2'b10);
      end
      $display("txn response owner=%0d", drain_tab[i]);
      step();
    end
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    logic own;
    logic exp_own;
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      idle();
      own = (i == 1);
      drive_owner(own, i);
      mem_addr_ok = 1'b1;
      exp_q.push_back(own);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      idle();
      own = (i % 3 == 0);
      drive_owner(own, i);
      mem_addr_ok = 1'b1;
      mem_data_ok = 1'b1;
      exp_own = exp_q.pop_front();
      exp_q.push_back(own);
      #1;
      n_cmp++;
      if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !==
          {1'b1, ~own, own, ~exp_own, exp_own}) begin
        n_bad++;
        $display("FAIL b2b_cycle%0d: got req/iaok/daok/iok/dok=%b want %b", i,
                 {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok},
                 {1'b1, ~own, own, ~exp_own, exp_own});
      end
      $display("txn b2b cycle=%0d accept owner=%0d response owner=%0d", i, own, exp_own);
      step();
    end
    // two more fit, the next one must see the FIFO full
    for (int i = 0; i < 3; i++) begin
      idle();
      own = (i == 0);
      drive_owner(own, 20 + i);
      mem_addr_ok = 1'b1;
      #1;
      n_cmp++;
      if (mem_req !== (i < 2)) begin
        n_bad++;
        $display("FAIL b2b_fill%0d: got mem_req=%b want %b", i, mem_req, (i < 2));
      end
      if (i < 2) exp_q.push_back(own);
      step();
    end
    idle();
    mem_data_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_own = exp_q.pop_front();
      #1;
      n_cmp++;
      if ({inst_data_ok, data_data_ok} !== {~exp_own, exp_own}) begin
        n_bad++;
        $display("FAIL b2b_drain%0d: got iok/dok=%b want %b", i, {inst_data_ok, data_data_ok}, {~exp_own, exp_own});
      end
      $display("txn response owner=%0d", exp_own);
      step();
    end
    idle();
    step();
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 3; i++) begin
      idle();
      drive_owner(i[0], i);
      mem_addr_ok = 1'b1;
      step();
    end
    idle();
    #2;
    resetn = 1'b0;
    #1;
    mem_data_ok = 1'b1;
    #1;
    n_cmp++;
    if ({mem_req, inst_data_ok, data_data_ok} !== 3'b000) begin
      n_bad++;
      $display("FAIL mid_reset_empty: got req/iok/dok=%b want 000", {mem_req, inst_data_ok, data_data_ok});
    end
    idle();
    @(negedge clk);
    resetn = 1'b1;
    step();
    mem_data_ok = 1'b1;
    #1;
    n_cmp++;
    if ({inst_data_ok, data_data_ok} !== 2'b00) begin
      n_bad++;
      $display("FAIL mid_stray_ok: got iok/dok=%b want 00", {inst_data_ok, data_data_ok});
    end
    step();
    // a fresh data request after the stray response must still route correctly
    idle();
    drive_owner(1'b1, 30);
    mem_addr_ok = 1'b1;
    step();
    idle();
    mem_data_ok = 1'b1;
    #1;
    n_cmp++;
    if ({inst_data_ok, data_data_ok} !== 2'b01) begin
      n_bad++;
      $display("FAIL mid_after_reset_route: got iok/dok=%b want 01", {inst_data_ok, data_data_ok});
    end
    $display("txn response owner=1 after reset");
    step();
    idle();
    step();
  endtask

  initial begin
    idle();
    resetn = 1'b0;
    test_reset();
    test_priority();
    test_order();
    test_full();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
